// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART
// transmitter among NUM_REQ requesters, with a WAIT timeout.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [IW-1:0]                 grant_idx,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           winner;
  logic [IW-1:0]           scan;
  logic                    found;
  logic [15:0]             cnt;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy = (state != S_IDLE);

  // Round-robin search starting just after the pointer, with wrap.
  always_comb begin
    winner = '0;
    scan   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  // Only the winner sees ready, and only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && found)
      req_ready[winner] = 1'b1;
  end

  // Scheduler FSM with registered start/done/timeout pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_done    <= '0;
      timeout_err <= 1'b0;
      grant_idx   <= '0;
      ptr         <= IW'(NUM_REQ - 1);
      cnt         <= '0;
    end else begin
      tx_start    <= 1'b0;
      req_done    <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            tx_data   <= data_arr[winner];
            grant_idx <= winner;
            tx_start  <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            req_done[grant_idx] <= 1'b1;
            ptr                 <= grant_idx;
            state               <= S_IDLE;
          end else if (cnt == TMAX) begin
            timeout_err <= 1'b1;
            ptr         <= grant_idx;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for
// uart_tx_scheduler with NUM_REQ=4 and TIMEOUT_CYCLES=16.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_idx;
  logic        timeout_err;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  uart_tx_scheduler #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .req_done(req_done),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .busy(busy),
    .grant_idx(grant_idx),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full grant: accept, start, wait n cycles, done.
  task automatic serve(input int idx, input logic [7:0] d,
                       input int n);
    #1 chk($sformatf("ready_%0d", idx), req_ready, 32'(1 << idx));
    @(negedge clk);
    chk("start_pulse", tx_start, 1);
    chk("start_data", tx_data, d);
    chk("start_grant", grant_idx, idx);
    chk("start_noready", req_ready, 0);
    @(negedge clk);
    chk("wait_start_low", tx_start, 0);
    chk("wait_busy", busy, 1);
    repeat (n) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk($sformatf("done_%0d", idx), req_done, 32'(1 << idx));
    chk("done_idle", busy, 0);
    chk("done_data_hold", tx_data, d);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    tx_done   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_done", req_done, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_grant", grant_idx, 0);

    // Single request, with a stray tx_done during START.
    rst       = 1'b0;
    req_valid = 4'b0001;
    req_data  = {8'h13, 8'h12, 8'h11, 8'hA5};
    #1 chk("single_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_busy", busy, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("ign_done_busy", busy, 1);
    chk("ign_done_rdone", req_done, 0);
    chk("ign_start_low", tx_start, 0);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("single_done", req_done, 4'b0001);
    chk("single_idle", busy, 0);
    @(negedge clk);
    chk("single_done_1cyc", req_done, 0);

    // Contention from reset pointer: 0,1,2,3,0.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    serve(0, 8'h10, 0);
    serve(1, 8'h11, 1);
    serve(2, 8'h12, 2);
    serve(3, 8'h13, 0);
    serve(0, 8'h10, 1);

    // Reset during WAIT aborts the grant.
    req_valid = 4'b0001;
    #1 chk("abort_ready", req_ready, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wait", busy, 1);
    rst       = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    #1 chk("abort_ready_rst", req_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_start", tx_start, 0);
    chk("abort_data", tx_data, 0);
    chk("abort_grant", grant_idx, 0);
    chk("abort_done", req_done, 0);
    chk("abort_tmo", timeout_err, 0);
    rst = 1'b0;
    serve(2, 8'h12, 0);

    // Pointer at 2, valid 0011: wrap to 0, then 1.
    req_valid = 4'b0011;
    serve(0, 8'h10, 0);
    serve(1, 8'h11, 0);

    // Timeout on requester 2, then 3 is granted.
    req_valid = 4'b1100;
    #1 chk("tmo_ready", req_ready, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("tmo_early", timeout_err, 0);
    chk("tmo_early_busy", busy, 1);
    @(negedge clk);
    chk("tmo_pulse", timeout_err, 1);
    chk("tmo_no_done", req_done, 0);
    chk("tmo_idle", busy, 0);
    #1 chk("tmo_next_ready", req_ready, 4'b1000);
    @(negedge clk);
    chk("tmo_next_start", tx_start, 1);
    chk("tmo_next_grant", grant_idx, 3);
    chk("tmo_pulse_1cyc", timeout_err, 0);
    @(negedge clk);
    repeat (15) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done   = 1'b0;
    req_valid = 4'b0000;
    chk("coinc_done", req_done, 4'b1000);
    chk("coinc_no_tmo", timeout_err, 0);
    chk("coinc_idle", busy, 0);
    @(negedge clk);
    chk("coinc_no_late_tmo", timeout_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
